ppu_cpu_write_port: RTL

CPU-to-PPU register write port: decodes CPU writes to $2000-$2007 and holds the state they configure. Outputs are ppu_ctrl0, ppu_ctrl1, OAM address, scroll and VRAM address registers. Owns the shared first/second write toggle used by $2005/$2006; a CPU read of $2002 clears it. Sits beside the status latch on the CPU bus and forwards $2004/$2007 data writes to the OAM and VRAM arbiters.

---
 rtl/ppu_cpu_write_port.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/ppu_cpu_write_port.sv
// CPU-side write port for the PPU register block ($2000-$2007).
// Define PPU_REG_MIRROR_EN to decode the whole $2000-$3FFF mirror range.
module ppu_cpu_write_port (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_data,
  input  logic        cpu_write,
  input  logic        cpu_read,
  output logic [7:0]  ppu_ctrl0,
  output logic [7:0]  ppu_ctrl1,
  output logic [7:0]  oam_addr,
  output logic        oam_wr_en,
  output logic [7:0]  oam_wr_addr,
  output logic [7:0]  oam_wr_data,
  output logic [7:0]  scroll_x,
  output logic [7:0]  scroll_y,
  output logic [13:0] vram_addr,
  output logic        vram_wr_req,
  output logic [13:0] vram_wr_addr,
  output logic [7:0]  vram_wr_data,
  input  logic        vram_wr_ack,
  output logic        write_toggle,
  output logic        vram_wr_overrun
);

  localparam logic [2:0] REG_CTRL0  = 3'd0;
  localparam logic [2:0] REG_CTRL1  = 3'd1;
  localparam logic [2:0] REG_OAMADR = 3'd3;
  localparam logic [2:0] REG_OAMDAT = 3'd4;
  localparam logic [2:0] REG_SCROLL = 3'd5;
  localparam logic [2:0] REG_VADDR  = 3'd6;
  localparam logic [2:0] REG_VDATA  = 3'd7;
  localparam logic [2:0] REG_STATUS = 3'd2;

  logic        cpu_write_q;
  logic [7:0]  ppu_ctrl0_q, ppu_ctrl0_d;
  logic [7:0]  ppu_ctrl1_q, ppu_ctrl1_d;
  logic [7:0]  oam_addr_q, oam_addr_d;
  logic        oam_wr_en_q, oam_wr_en_d;
  logic [7:0]  oam_wr_addr_q, oam_wr_addr_d;
  logic [7:0]  oam_wr_data_q, oam_wr_data_d;
  logic [7:0]  scroll_x_q, scroll_x_d;
  logic [7:0]  scroll_y_q, scroll_y_d;
  logic [13:0] vram_addr_q, vram_addr_d;
  logic        vram_wr_req_q, vram_wr_req_d;
  logic [13:0] vram_wr_addr_q, vram_wr_addr_d;
  logic [7:0]  vram_wr_data_q, vram_wr_data_d;
  logic        toggle_q, toggle_d;
  logic        overrun_q, overrun_d;

  logic        hit;
  logic        wr_pulse;
  logic        rd_clear;
  logic [2:0]  sel;
  logic [13:0] vram_step;

`ifdef PPU_REG_MIRROR_EN
  assign hit = (cpu_addr[15:13] == 3'b001);
`else
  assign hit = (cpu_addr[15:3] == 13'h0400);
`endif

  assign sel       = cpu_addr[2:0];
  assign wr_pulse  = cpu_write & ~cpu_write_q & hit;
  assign rd_clear  = cpu_read & hit & (sel == REG_STATUS);
  assign vram_step = ppu_ctrl0_q[2] ? 14'd32 : 14'd1;

  always_comb begin
    ppu_ctrl0_d    = ppu_ctrl0_q;
    ppu_ctrl1_d    = ppu_ctrl1_q;
    oam_addr_d     = oam_addr_q;
    oam_wr_en_d    = 1'b0;
    oam_wr_addr_d  = oam_wr_addr_q;
    oam_wr_data_d  = oam_wr_data_q;
    scroll_x_d     = scroll_x_q;
    scroll_y_d     = scroll_y_q;
    vram_addr_d    = vram_addr_q;
    vram_wr_req_d  = vram_wr_req_q;
    vram_wr_addr_d = vram_wr_addr_q;
    vram_wr_data_d = vram_wr_data_q;
    toggle_d       = toggle_q;
    overrun_d      = overrun_q;

    if (vram_wr_req_q && vram_wr_ack) begin
      vram_wr_req_d = 1'b0;
    end

    if (wr_pulse) begin
      case (sel)
        REG_CTRL0:  ppu_ctrl0_d = cpu_data;
        REG_CTRL1:  ppu_ctrl1_d = cpu_data;
        REG_OAMADR: oam_addr_d  = cpu_data;
        REG_OAMDAT: begin
          oam_wr_en_d   = 1'b1;
          oam_wr_addr_d = oam_addr_q;
          oam_wr_data_d = cpu_data;
          oam_addr_d    = oam_addr_q + 8'd1;
        end
        REG_SCROLL: begin
          if (!toggle_q) scroll_x_d = cpu_data;
          else           scroll_y_d = cpu_data;
          toggle_d = ~toggle_q;
        end
        REG_VADDR: begin
          if (!toggle_q) vram_addr_d[13:8] = cpu_data[5:0];
          else           vram_addr_d[7:0]  = cpu_data;
          toggle_d = ~toggle_q;
        end
        REG_VDATA: begin
          // An ack in the same cycle frees the slot, so the new write is taken.
          if (!vram_wr_req_q || vram_wr_ack) begin
            vram_wr_addr_d = vram_addr_q;
            vram_wr_data_d = cpu_data;
            vram_wr_req_d  = 1'b1;
            vram_addr_d    = vram_addr_q + vram_step;
          end else begin
            overrun_d = 1'b1;
          end
        end
        default: ;
      endcase
    end

    // Status read wins over a same-cycle toggle flip.
    if (rd_clear) begin
      toggle_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cpu_write_q    <= 1'b0;
      ppu_ctrl0_q    <= '0;
      ppu_ctrl1_q    <= '0;
      oam_addr_q     <= '0;
      oam_wr_en_q    <= 1'b0;
      oam_wr_addr_q  <= '0;
      oam_wr_data_q  <= '0;
      scroll_x_q     <= '0;
      scroll_y_q     <= '0;
      vram_addr_q    <= '0;
      vram_wr_req_q  <= 1'b0;
      vram_wr_addr_q <= '0;
      vram_wr_data_q <= '0;
      toggle_q       <= 1'b0;
      overrun_q      <= 1'b0;
    end else begin
      cpu_write_q    <= cpu_write;
      ppu_ctrl0_q    <= ppu_ctrl0_d;
      ppu_ctrl1_q    <= ppu_ctrl1_d;
      oam_addr_q     <= oam_addr_d;
      oam_wr_en_q    <= oam_wr_en_d;
      oam_wr_addr_q  <= oam_wr_addr_d;
      oam_wr_data_q  <= oam_wr_data_d;
      scroll_x_q     <= scroll_x_d;
      scroll_y_q     <= scroll_y_d;
      vram_addr_q    <= vram_addr_d;
      vram_wr_req_q  <= vram_wr_req_d;
      vram_wr_addr_q <= vram_wr_addr_d;
      vram_wr_data_q <= vram_wr_data_d;
      toggle_q       <= toggle_d;
      overrun_q      <= overrun_d;
    end
  end

  assign ppu_ctrl0       = ppu_ctrl0_q;
  assign ppu_ctrl1       = ppu_ctrl1_q;
  assign oam_addr        = oam_addr_q;
  assign oam_wr_en       = oam_wr_en_q;
  assign oam_wr_addr     = oam_wr_addr_q;
  assign oam_wr_data     = oam_wr_data_q;
  assign scroll_x        = scroll_x_q;
  assign scroll_y        = scroll_y_q;
  assign vram_addr       = vram_addr_q;
  assign vram_wr_req     = vram_wr_req_q;
  assign vram_wr_addr    = vram_wr_addr_q;
  assign vram_wr_data    = vram_wr_data_q;
  assign write_toggle    = toggle_q;
  assign vram_wr_overrun = overrun_q;

endmodule
